// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-bus arbiter: FSM states, requester
// owner IDs and default priority order.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Owner values double as bit positions in the one-hot grant vector.
    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_RD = 2'd1,
        OWN_WR = 2'd2
    } owner_e;

    localparam owner_e PRIO_HI  = OWN_WR;
    localparam owner_e PRIO_MID = OWN_RD;
    localparam owner_e PRIO_LO  = OWN_IF;

endpackage

// File: rtl/arb_prio.sv
// Combinational fixed-priority select (write > read > fetch) with a fetch
// starvation override; produces a one-hot grant indexed by owner_e.
module arb_prio
    import mem_arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       rd_req_i,
    input  logic       wr_req_i,
    input  logic       starve_hit_i,
    output logic [2:0] gnt_o
);

    logic [2:0] req;

    always_comb begin
        req         = '0;
        req[OWN_IF] = if_req_i;
        req[OWN_RD] = rd_req_i;
        req[OWN_WR] = wr_req_i;
    end

    always_comb begin
        gnt_o = '0;
        if (starve_hit_i && req[OWN_IF]) begin
            gnt_o[OWN_IF] = 1'b1;
        end else if (req[PRIO_HI]) begin
            gnt_o[PRIO_HI] = 1'b1;
        end else if (req[PRIO_MID]) begin
            gnt_o[PRIO_MID] = 1'b1;
        end else if (req[PRIO_LO]) begin
            gnt_o[PRIO_LO] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch, load and store requests onto one handshaked memory bus,
// returning data with a one-cycle ack and stalling the pipeline meanwhile.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_rd_req_i,
    input  logic [ADDR_W-1:0] dm_rd_addr_i,
    output logic [DATA_W-1:0] dm_rd_data_o,
    output logic              dm_rd_ack_o,
    input  logic              dm_wr_req_i,
    input  logic [ADDR_W-1:0] dm_wr_addr_i,
    input  logic [DATA_W-1:0] dm_wr_data_i,
    output logic              dm_wr_ack_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              hold_flag_o,
    output logic              err_o
);

    localparam int unsigned SV_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e            state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [SV_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   to_q;
    logic [DATA_W-1:0] if_data_q, rd_data_q;
    logic              if_ack_q, rd_ack_q, wr_ack_q, err_q;
    logic [2:0]        gnt;
    logic              starve_hit;
    logic              resp_now;

    assign starve_hit = if_req_i && (starve_q == SV_W'(STARVE_MAX));

    arb_prio u_arb_prio (
        .if_req_i     (if_req_i),
        .rd_req_i     (dm_rd_req_i),
        .wr_req_i     (dm_wr_req_i),
        .starve_hit_i (starve_hit),
        .gnt_o        (gnt)
    );

    // Starvation tracks only fetch losses at arbitration; a dropped fetch resets it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i) begin
            starve_d = '0;
        end else if (state_q == IDLE && (|gnt)) begin
            if (gnt[OWN_IF]) begin
                starve_d = '0;
            end else if (starve_q != SV_W'(STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    assign resp_now = bus_rvalid_i || (to_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            starve_q  <= '0;
            to_q      <= '0;
            if_data_q <= '0;
            rd_data_q <= '0;
            if_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        state_q <= ADDR;
                        if (gnt[OWN_WR]) begin
                            owner_q <= OWN_WR;
                            addr_q  <= dm_wr_addr_i;
                            wdata_q <= dm_wr_data_i;
                            we_q    <= 1'b1;
                        end else if (gnt[OWN_RD]) begin
                            owner_q <= OWN_RD;
                            addr_q  <= dm_rd_addr_i;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end else begin
                            owner_q <= OWN_IF;
                            addr_q  <= if_addr_i;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    if (bus_gnt_i) begin
                        to_q <= '0;
                        if (we_q) begin
                            state_q  <= RESP;
                            wr_ack_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (resp_now) begin
                        state_q <= RESP;
                        err_q   <= !bus_rvalid_i;
                        if (owner_q == OWN_IF) begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= bus_rvalid_i ? bus_rdata_i : '0;
                        end else begin
                            rd_ack_q  <= 1'b1;
                            rd_data_q <= bus_rvalid_i ? bus_rdata_i : '0;
                        end
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_o    = (state_q == ADDR);
    assign bus_we_o     = bus_req_o && we_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign if_data_o    = if_data_q;
    assign if_ack_o     = if_ack_q;
    assign dm_rd_data_o = rd_data_q;
    assign dm_rd_ack_o  = rd_ack_q;
    assign dm_wr_ack_o  = wr_ack_q;
    assign err_o        = err_q;

    assign hold_flag_o = !rst && ((if_req_i && !if_ack_o) ||
                                  (dm_rd_req_i && !dm_rd_ack_o) ||
                                  (dm_wr_req_i && !dm_wr_ack_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, priority, starvation,
// timeout, reset mid-access and stalled bus grant.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, dm_rd_req_i, dm_wr_req_i;
    logic [31:0] if_addr_i, dm_rd_addr_i, dm_wr_addr_i, dm_wr_data_i;
    logic [31:0] if_data_o, dm_rd_data_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        if_ack_o, dm_rd_ack_o, dm_wr_ack_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
    logic        hold_flag_o, err_o;

    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_rd_req_i(dm_rd_req_i), .dm_rd_addr_i(dm_rd_addr_i),
        .dm_rd_data_o(dm_rd_data_o), .dm_rd_ack_o(dm_rd_ack_o),
        .dm_wr_req_i(dm_wr_req_i), .dm_wr_addr_i(dm_wr_addr_i),
        .dm_wr_data_i(dm_wr_data_i), .dm_wr_ack_o(dm_wr_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .hold_flag_o(hold_flag_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned cnt;
    int unsigned n_rd;
    logic        got_if;
    logic        seen;

    initial begin
        rst = 1'b1;
        if_req_i = 0; dm_rd_req_i = 0; dm_wr_req_i = 0;
        if_addr_i = '0; dm_rd_addr_i = '0; dm_wr_addr_i = '0; dm_wr_data_i = '0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
        #1;
        check_eq("reset_ctrl", {bus_req_o, bus_we_o, if_ack_o, dm_rd_ack_o, dm_wr_ack_o, hold_flag_o, err_o}, 0);
        check_eq("reset_data", {if_data_o, dm_rd_data_o}, 0);
        check_eq("reset_bus", {bus_addr_o, bus_wdata_o}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single fetch with gnt in cycle 1, rvalid in cycle 2
        if_req_i = 1; if_addr_i = 32'h0000_0010;
        #1 check_eq("fetch_c0_hold", hold_flag_o, 1);
        tick();
        check_eq("fetch_c1_bus", {bus_req_o, bus_we_o, bus_addr_o}, {2'b10, 32'h10});
        check_eq("fetch_c1_hold", hold_flag_o, 1);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        check_eq("fetch_c2_state", {bus_req_o, if_ack_o, hold_flag_o}, 3'b001);
        bus_rvalid_i = 1; bus_rdata_i = 32'h0050_0093;
        tick();
        bus_rvalid_i = 0;
        check_eq("fetch_c3_ack", {if_ack_o, hold_flag_o}, 2'b10);
        check_eq("fetch_c3_data", if_data_o, 32'h0050_0093);
        if_req_i = 0;
        tick();
        check_eq("fetch_c4_ack_low", if_ack_o, 0);
        check_eq("fetch_c4_data_held", if_data_o, 32'h0050_0093);

        // Write and read in the same cycle: write first, one IDLE gap, then read
        bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h1234_5678;
        dm_wr_req_i = 1; dm_wr_addr_i = 32'h100; dm_wr_data_i = 32'hDEAD_BEEF;
        dm_rd_req_i = 1; dm_rd_addr_i = 32'h104;
        tick();
        check_eq("wr_first_bus", {bus_req_o, bus_we_o, bus_addr_o}, {2'b11, 32'h100});
        check_eq("wr_first_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        tick();
        check_eq("wr_ack", {dm_wr_ack_o, dm_rd_ack_o}, 2'b10);
        dm_wr_req_i = 0;
        tick();
        check_eq("idle_gap", {bus_req_o, dm_wr_ack_o}, 2'b00);
        tick();
        check_eq("rd_second_bus", {bus_req_o, bus_we_o, bus_addr_o}, {2'b10, 32'h104});
        tick();
        check_eq("rd_wait_no_ack", dm_rd_ack_o, 0);
        tick();
        check_eq("rd_ack", dm_rd_ack_o, 1);
        check_eq("rd_data", dm_rd_data_o, 32'h1234_5678);
        dm_rd_req_i = 0;
        tick();

        // Starvation: fetch pending while loads keep winning
        bus_rdata_i = 32'h1111_2222;
        if_req_i = 1; if_addr_i = 32'h200;
        dm_rd_req_i = 1; dm_rd_addr_i = 32'h300;
        n_rd = 0; got_if = 0;
        for (int i = 0; i < 60 && !got_if; i++) begin
            tick();
            if (bus_req_o) begin
                if (bus_addr_o == 32'h200) got_if = 1;
                else n_rd++;
            end
        end
        check_eq("starve_if_granted", got_if, 1);
        check_eq("starve_loads_before_if", n_rd, 4);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = if_ack_o;
        end
        check_eq("starve_if_ack", seen, 1);
        check_eq("starve_if_data", if_data_o, 32'h1111_2222);
        if_req_i = 0; dm_rd_req_i = 0;
        tick(); tick();

        // Timeout: rvalid never returned
        bus_rvalid_i = 0;
        dm_rd_req_i = 1; dm_rd_addr_i = 32'h400;
        cnt = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            cnt++;
            seen = dm_rd_ack_o;
        end
        check_eq("timeout_ack", seen, 1);
        check_eq("timeout_cycles", cnt, 257);
        check_eq("timeout_err", err_o, 1);
        check_eq("timeout_data_zero", dm_rd_data_o, 0);
        dm_rd_req_i = 0;
        tick();
        check_eq("timeout_err_pulse", {err_o, dm_rd_ack_o, bus_req_o}, 3'b000);

        // Reset while in WAIT, stale rvalid afterwards
        dm_rd_req_i = 1; dm_rd_addr_i = 32'h500;
        tick(); tick(); tick();
        rst = 1; dm_rd_req_i = 0; if_req_i = 1;
        #1;
        check_eq("midrst_ctrl", {bus_req_o, if_ack_o, dm_rd_ack_o, dm_wr_ack_o, hold_flag_o, err_o}, 0);
        check_eq("midrst_data", {if_data_o, dm_rd_data_o}, 0);
        check_eq("midrst_bus_addr", bus_addr_o, 0);
        if_req_i = 0;
        tick();
        rst = 0;
        bus_rvalid_i = 1; bus_rdata_i = 32'h0000_0BAD;
        tick();
        bus_rvalid_i = 0;
        tick();
        check_eq("stale_no_ack", {dm_rd_ack_o, if_ack_o, bus_req_o}, 3'b000);
        check_eq("stale_no_data", dm_rd_data_o, 0);
        dm_rd_req_i = 1; dm_rd_addr_i = 32'h600;
        bus_rvalid_i = 1; bus_rdata_i = 32'h600D_600D;
        tick(); tick();
        check_eq("post_rst_no_early_ack", dm_rd_ack_o, 0);
        tick();
        check_eq("post_rst_ack", dm_rd_ack_o, 1);
        check_eq("post_rst_data", dm_rd_data_o, 32'h600D_600D);
        dm_rd_req_i = 0; bus_rvalid_i = 0;
        tick();

        // Write with gnt held low for 10 cycles
        bus_gnt_i = 0;
        dm_wr_req_i = 1; dm_wr_addr_i = 32'h700; dm_wr_data_i = 32'hCAFE_F00D;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_bus_stable", {bus_req_o, dm_wr_ack_o, bus_addr_o}, {2'b10, 32'h700});
            tick();
        end
        bus_gnt_i = 1;
        check_eq("stall_gnt_cycle", {bus_req_o, bus_we_o, dm_wr_ack_o}, 3'b110);
        tick();
        check_eq("stall_ack", dm_wr_ack_o, 1);
        dm_wr_req_i = 0;
        tick();
        check_eq("stall_ack_pulse", {dm_wr_ack_o, bus_req_o}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
